// File: rtl/increment_source_mux_pkg.sv
// Shared definitions for the increment source selector: FSM state encodings,
// default timing constants and a small helper for sizing the repeat counter.
package increment_source_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/increment_source_mux_if.sv
// Bundles the source-side inputs and the increment outputs of the selector.
interface increment_source_mux_if
  import increment_source_mux_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] in;
  logic [NUM_CH-1:0] repeat_en;
  logic              inc;
  logic [SEL_W-1:0]  active_ch;

  modport master (output sel, output in, output repeat_en, input inc, input active_ch);
  modport slave  (input sel, input in, input repeat_en, output inc, output active_ch);
endinterface

// File: rtl/increment_source_mux_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one source.
// The detector stays disarmed until a genuine synchronised low has been seen,
// so a source that is already high when reset releases never yields a pulse.
module sync_edge
  import increment_source_mux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o
);
  logic s1_q, s2_q, p_q;
  logic v1_q, v2_q, arm_q;

  // Synchroniser, edge history, and arming once a valid low is observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      p_q   <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      s1_q  <= in_i;
      s2_q  <= s1_q;
      p_q   <= s2_q;
      v1_q  <= 1'b1;
      v2_q  <= v1_q;
      arm_q <= arm_q | (v2_q & ~s2_q);
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~p_q & arm_q;
endmodule

// File: rtl/increment_source_mux.sv
// Selects one of NUM_CH increment sources and emits a one-cycle inc pulse per
// synchronised rising edge, with optional hold-then-repeat while held high.
//
// state     | meaning
// ST_IDLE   | waiting for a rising edge on the selected source
// ST_HOLD   | source held after first pulse, counting to HOLD_CYCLES
// ST_REPEAT | auto-repeating every REPEAT_CYCLES while source stays high
module increment_source_mux
  import increment_source_mux_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int SEL_W         = $clog2(NUM_CH),
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
)(
  input logic clk,
  input logic rst,
  increment_source_mux_if.slave bus
);
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] rise;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .in_i    (bus.in[g]),
      .level_o (lvl[g]),
      .rise_o  (rise[g])
    );
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_q, inc_d;
  logic [SEL_W-1:0] sel_q;

  logic sel_ok, switch_pend, lvl_sel, rise_sel, rep_sel;

  // Selected-channel view; out-of-range selects read as an idle channel.
  always_comb begin
    sel_ok      = {1'b0, sel_q} < (SEL_W+1)'(NUM_CH);
    switch_pend = (bus.sel != sel_q);
    lvl_sel     = 1'b0;
    rise_sel    = 1'b0;
    rep_sel     = 1'b0;
    if (sel_ok) begin
      lvl_sel  = lvl[sel_q];
      rise_sel = rise[sel_q];
      rep_sel  = bus.repeat_en[sel_q];
    end
  end

  // Next-state, counter and pulse decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc_d   = 1'b0;
    if (switch_pend || !sel_ok) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_sel) begin
            inc_d = 1'b1;
            if (rep_sel) begin
              state_d = ST_HOLD;
              cnt_d   = '0;
            end
          end
        end
        ST_HOLD: begin
          if (!lvl_sel || !rep_sel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            inc_d   = 1'b1;
            state_d = ST_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!lvl_sel || !rep_sel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            inc_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, select and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      sel_q   <= bus.sel;
    end
  end

  assign bus.inc       = inc_q;
  assign bus.active_ch = sel_q;
endmodule

// File: tb/tb_increment_source_mux.sv
module tb_increment_source_mux;
  import increment_source_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_mask;

  increment_source_mux_if #(.NUM_CH(4)) bus4 ();
  increment_source_mux_if #(.NUM_CH(3)) bus3 ();

  increment_source_mux #(.NUM_CH(4), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );
  increment_source_mux #(.NUM_CH(3), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int mbit(input logic [31:0] m, input int c);
    return int'((m >> c) & 32'd1);
  endfunction

  initial begin
    rst = 1'b1;
    bus4.sel = 2'd0; bus4.in = 4'd0; bus4.repeat_en = 4'd0;
    bus3.sel = 2'd0; bus3.in = 3'd0; bus3.repeat_en = 3'd0;
    repeat (2) tick();
    chk("rst_inc", int'(bus4.inc), 0);
    chk("rst_active", int'(bus4.active_ch), 0);
    chk("rst_state", int'(u_dut4.state_q), int'(ST_IDLE));
    chk("rst_cnt", int'(u_dut4.cnt_q), 0);
    chk("rst_inc3", int'(bus3.inc), 0);
    rst = 1'b0;
    repeat (5) tick();

    // Basic pulse on channel 1, no repeat.
    bus4.sel = 2'd1;
    repeat (3) tick();
    chk("basic_active", int'(bus4.active_ch), 1);
    exp_mask = 32'h0000_0004;
    for (int c = 0; c < 30; c++) begin
      bus4.in[1] = (c < 20);
      tick();
      chk($sformatf("basic_inc_c%0d", c), int'(bus4.inc), mbit(exp_mask, c));
    end

    // Auto-repeat on channel 2; the terminal count coincident with the
    // synchronised fall must not pulse.
    bus4.sel = 2'd2; bus4.repeat_en = 4'b0100;
    repeat (3) tick();
    exp_mask = 32'h0000_1544;
    for (int c = 0; c < 25; c++) begin
      bus4.in[2] = (c < 12);
      tick();
      chk($sformatf("rep_inc_c%0d", c), int'(bus4.inc), mbit(exp_mask, c));
    end
    chk("rep_state_end", int'(u_dut4.state_q), int'(ST_IDLE));

    // repeat_en dropped while holding: no further pulses.
    repeat (2) tick();
    exp_mask = 32'h0000_0004;
    for (int c = 0; c < 16; c++) begin
      bus4.in[2] = (c < 14);
      bus4.repeat_en[2] = (c < 4);
      tick();
      chk($sformatf("repoff_inc_c%0d", c), int'(bus4.inc), mbit(exp_mask, c));
    end

    // Channel switch 0 -> 3 on the cycle of a channel-0 rise.
    bus4.sel = 2'd0; bus4.repeat_en = 4'd0; bus4.in = 4'd0;
    repeat (3) tick();
    exp_mask = 32'h0004_1044;
    for (int c = 0; c < 28; c++) begin
      bus4.in[0] = ((c % 4) < 2);
      bus4.in[3] = (c == 10) || (c == 11) || (c == 16) || (c == 17);
      bus4.sel   = (c >= 10) ? 2'd3 : 2'd0;
      tick();
      chk($sformatf("sw_inc_c%0d", c), int'(bus4.inc), mbit(exp_mask, c));
    end
    chk("sw_active", int'(bus4.active_ch), 3);

    // Unselected noise on channels 1..3.
    bus4.sel = 2'd0; bus4.repeat_en = 4'hF; bus4.in = 4'd0;
    repeat (3) tick();
    for (int c = 0; c < 20; c++) begin
      bus4.in = (c % 2 == 1) ? 4'b1110 : 4'b0000;
      tick();
      chk($sformatf("noise_inc_c%0d", c), int'(bus4.inc), 0);
      chk($sformatf("noise_state_c%0d", c), int'(u_dut4.state_q), int'(ST_IDLE));
    end
    bus4.in = 4'd0;

    // Out-of-range select on the 3-channel instance.
    bus3.sel = 2'd3; bus3.repeat_en = 3'b111;
    repeat (3) tick();
    for (int c = 0; c < 16; c++) begin
      bus3.in = (c % 2 == 1) ? 3'b111 : 3'b000;
      tick();
      chk($sformatf("oor_inc_c%0d", c), int'(bus3.inc), 0);
    end
    chk("oor_active", int'(bus3.active_ch), 3);
    bus3.in = 3'd0; bus3.sel = 2'd2; bus3.repeat_en = 3'd0;
    repeat (4) tick();
    exp_mask = 32'h0000_0004;
    for (int c = 0; c < 8; c++) begin
      bus3.in[2] = (c < 5);
      tick();
      chk($sformatf("ch3_inc_c%0d", c), int'(bus3.inc), mbit(exp_mask, c));
    end

    // Reset asserted between edges while in REPEAT with the source high.
    bus4.sel = 2'd2; bus4.repeat_en = 4'b0100; bus4.in = 4'd0;
    repeat (3) tick();
    exp_mask = 32'h0000_0144;
    for (int c = 0; c < 9; c++) begin
      bus4.in[2] = 1'b1;
      tick();
      chk($sformatf("prerst_inc_c%0d", c), int'(bus4.inc), mbit(exp_mask, c));
    end
    rst = 1'b1;
    #1;
    chk("async_rst_inc", int'(bus4.inc), 0);
    chk("async_rst_active", int'(bus4.active_ch), 0);
    chk("async_rst_state", int'(u_dut4.state_q), int'(ST_IDLE));
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("postrst_inc_c%0d", c), int'(bus4.inc), 0);
    end
    chk("postrst_active", int'(bus4.active_ch), 2);
    exp_mask = 32'h0000_0440;
    for (int c = 0; c < 12; c++) begin
      bus4.in[2] = (c >= 4);
      tick();
      chk($sformatf("rerise_inc_c%0d", c), int'(bus4.inc), mbit(exp_mask, c));
    end
    bus4.in = 4'd0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
